// File: rtl/mem_stage.sv
// MEM stage: waits for load data, aligns and extends it, and registers MEM/WB (1 cycle, plus WAIT cycles on slow loads).
// Stalls upstream while a load waits; defining MEM_ALIGN_EXC_EN adds the registered align_err output for misaligned half/word loads.
module mem_stage #(
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_flush,
  input  logic          in_reg_write,
  input  logic          in_mem_to_reg,
  input  logic          in_is_byte,
  input  logic          in_is_half,
  input  logic          in_load_sign,
  input  logic [RW-1:0] in_rw,
  input  logic [DW-1:0] in_exout,
  input  logic [DW-1:0] dm_rdata,
  input  logic          dm_rvalid,
  output logic          stall_req,
  output logic          mem_back_we,
  output logic [RW-1:0] mem_back_rw,
  output logic [DW-1:0] mem_back_data,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_rw,
  output logic [DW-1:0] wb_data,
`ifdef MEM_ALIGN_EXC_EN
  output logic          align_err,
`endif
  output logic          bus_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_we_q, wb_we_d;
  logic [RW-1:0] wb_rw_q, wb_rw_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          bus_err_q, bus_err_d;
  logic          we;
  logic          misalign;
  logic [1:0]    a;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;

  assign we            = in_reg_write && (in_rw != '0);
  assign a             = in_exout[1:0];
  assign mem_back_we   = we && !in_mem_to_reg;
  assign mem_back_rw   = in_rw;
  assign mem_back_data = in_exout;

`ifdef MEM_ALIGN_EXC_EN
  logic align_err_q, align_err_d;
  assign misalign  = in_mem_to_reg && !in_is_byte &&
                     (in_is_half ? a[0] : (a != 2'b00));
  assign align_err = align_err_q;
`else
  assign misalign  = 1'b0;
`endif

  // Little-endian lane select; sign bit only propagates for signed byte/half loads.
  always_comb begin
    ld_byte = dm_rdata[{a, 3'b000} +: 8];
    ld_half = dm_rdata[{a[1], 4'b0000} +: 16];
    if (in_is_byte)
      ld_data = {{(DW-8){in_load_sign & ld_byte[7]}}, ld_byte};
    else if (in_is_half)
      ld_data = {{(DW-16){in_load_sign & ld_half[15]}}, ld_half};
    else
      ld_data = dm_rdata;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_we_d   = 1'b0;
    wb_rw_d   = wb_rw_q;
    wb_data_d = wb_data_q;
    bus_err_d = 1'b0;
    stall_req = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
    align_err_d = 1'b0;
`endif
    if (mem_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (!in_mem_to_reg) begin
        wb_we_d   = we;
        wb_rw_d   = in_rw;
        wb_data_d = in_exout;
      end else if (misalign) begin
`ifdef MEM_ALIGN_EXC_EN
        align_err_d = 1'b1;
`endif
      end else if (dm_rvalid) begin
        wb_we_d   = we;
        wb_rw_d   = in_rw;
        wb_data_d = ld_data;
      end else begin
        stall_req = 1'b1;
        state_d   = S_WAIT;
        cnt_d     = '0;
      end
    end else begin
      if (dm_rvalid) begin
        wb_we_d   = we;
        wb_rw_d   = in_rw;
        wb_data_d = ld_data;
        state_d   = S_IDLE;
        cnt_d     = '0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        // Last permitted WAIT cycle: give up, release the pipeline this cycle.
        bus_err_d = 1'b1;
        state_d   = S_IDLE;
        cnt_d     = '0;
      end else begin
        stall_req = 1'b1;
        cnt_d     = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_rw_q   <= '0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_we_q   <= wb_we_d;
      wb_rw_q   <= wb_rw_d;
      wb_data_q <= wb_data_d;
      bus_err_q <= bus_err_d;
`ifdef MEM_ALIGN_EXC_EN
      align_err_q <= align_err_d;
`endif
    end
  end

  assign wb_reg_write = wb_we_q;
  assign wb_rw        = wb_rw_q;
  assign wb_data      = wb_data_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: per-cycle expected MEM/WB results queued at drive time, compared after the edge.
module tb_mem_stage;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, mem_flush, in_reg_write, in_mem_to_reg, in_is_byte, in_is_half, in_load_sign;
  logic [4:0]  in_rw;
  logic [31:0] in_exout, dm_rdata;
  logic        dm_rvalid;
  logic        stall_req, mem_back_we, wb_reg_write, bus_err;
  logic [4:0]  mem_back_rw, wb_rw;
  logic [31:0] mem_back_data, wb_data;
`ifdef MEM_ALIGN_EXC_EN
  logic        align_err;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] data;
    logic        cd;
    logic        berr;
    logic        al;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  mem_stage #(.DW(32), .RW(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_flush(mem_flush),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_is_byte(in_is_byte), .in_is_half(in_is_half), .in_load_sign(in_load_sign),
    .in_rw(in_rw), .in_exout(in_exout), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .stall_req(stall_req), .mem_back_we(mem_back_we), .mem_back_rw(mem_back_rw),
    .mem_back_data(mem_back_data), .wb_reg_write(wb_reg_write), .wb_rw(wb_rw),
    .wb_data(wb_data),
`ifdef MEM_ALIGN_EXC_EN
    .align_err(align_err),
`endif
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic r, input logic f, input logic rwe, input logic m2r,
                       input logic b, input logic h, input logic s, input logic [4:0] rw,
                       input logic [31:0] ex, input logic [31:0] rd, input logic rv);
    rst = r; mem_flush = f; in_reg_write = rwe; in_mem_to_reg = m2r;
    in_is_byte = b; in_is_half = h; in_load_sign = s;
    in_rw = rw; in_exout = ex; dm_rdata = rd; dm_rvalid = rv;
  endtask

  // es/ebp: expected stall_req / mem_back_we this cycle, -1 means not checked.
  task automatic step(input int es, input int ebp, input logic ewe, input logic [4:0] erw,
                      input logic [31:0] ed, input logic cd, input logic eb, input logic eal);
    exp_t e;
    #1;
    if (es >= 0) chk("stall_req", {31'b0, stall_req}, es[31:0]);
    if (ebp >= 0) chk("mem_back_we", {31'b0, mem_back_we}, ebp[31:0]);
    if (ebp == 1) begin
      chk("mem_back_rw", {27'b0, mem_back_rw}, {27'b0, in_rw});
      chk("mem_back_data", mem_back_data, in_exout);
    end
    e.we = ewe; e.rw = erw; e.data = ed; e.cd = cd; e.berr = eb; e.al = eal;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, mon_e.we});
      chk("bus_err", {31'b0, bus_err}, {31'b0, mon_e.berr});
`ifdef MEM_ALIGN_EXC_EN
      chk("align_err", {31'b0, align_err}, {31'b0, mon_e.al});
`endif
      if (mon_e.cd) begin
        chk("wb_rw", {27'b0, wb_rw}, {27'b0, mon_e.rw});
        chk("wb_data", wb_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    @(negedge clk);
    // Reset state
    step(0, 0, 0, 5'd0, 32'h0, 1, 0, 0);
    step(0, 0, 0, 5'd0, 32'h0, 1, 0, 0);
    // ADD r8
    drive(0, 0, 1, 0, 0, 0, 0, 5'd8, 32'h1234, 32'h0, 0);
    step(0, 1, 1, 5'd8, 32'h1234, 1, 0, 0);
    // Write to r0 is suppressed
    drive(0, 0, 1, 0, 0, 0, 0, 5'd0, 32'h55, 32'h0, 0);
    step(0, 0, 0, 5'd0, 32'h55, 1, 0, 0);
    // LB, byte 3, signed, immediate data
    drive(0, 0, 1, 1, 1, 0, 1, 5'd3, 32'h1003, 32'h80FF_0000, 1);
    step(0, 0, 1, 5'd3, 32'hFFFF_FF80, 1, 0, 0);
    // LBU, byte 2
    drive(0, 0, 1, 1, 1, 0, 0, 5'd2, 32'h1002, 32'h80FF_0000, 1);
    step(0, 0, 1, 5'd2, 32'h0000_00FF, 1, 0, 0);
    // LHU upper half, data after 3 stall cycles
    drive(0, 0, 1, 1, 0, 1, 0, 5'd4, 32'h2002, 32'hBEEF_1234, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    dm_rvalid = 1;
    step(0, 0, 1, 5'd4, 32'h0000_BEEF, 1, 0, 0);
    // LH lower half, signed
    drive(0, 0, 1, 1, 0, 1, 1, 5'd5, 32'h2000, 32'h1234_8001, 1);
    step(0, 0, 1, 5'd5, 32'hFFFF_8001, 1, 0, 0);
    // LW immediate
    drive(0, 0, 1, 1, 0, 0, 0, 5'd6, 32'h3000, 32'hDEAD_BEEF, 1);
    step(0, 0, 1, 5'd6, 32'hDEAD_BEEF, 1, 0, 0);
    // Timeout: TO stall cycles then bus_err, write suppressed
    drive(0, 0, 1, 1, 0, 0, 0, 5'd7, 32'h4000, 32'h0, 0);
    for (int i = 0; i < TO; i++) step(1, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 5'd0, 32'h0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    step(0, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    // Data on the very last permitted WAIT cycle still completes
    drive(0, 0, 1, 1, 0, 0, 0, 5'd13, 32'h4100, 32'h0BAD_F00D, 0);
    for (int i = 0; i < TO; i++) step(1, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    dm_rvalid = 1;
    step(0, 0, 1, 5'd13, 32'h0BAD_F00D, 1, 0, 0);
    // Flush in WAIT cycle 2 with rvalid, then ADD r9
    drive(0, 0, 1, 1, 0, 0, 0, 5'd10, 32'h5000, 32'h1111_2222, 0);
    step(1, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    mem_flush = 1; dm_rvalid = 1;
    step(-1, -1, 0, 5'd0, 32'h0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 5'd9, 32'h99, 32'h0, 0);
    step(0, 1, 1, 5'd9, 32'h99, 1, 0, 0);
    // rvalid with no load present is ignored
    drive(0, 0, 1, 0, 0, 0, 0, 5'd11, 32'hABC, 32'hFFFF_FFFF, 1);
    step(0, 1, 1, 5'd11, 32'hABC, 1, 0, 0);
    // Reset mid-WAIT aborts without bus_err
    drive(0, 0, 1, 1, 0, 0, 0, 5'd12, 32'h6000, 32'h0, 0);
    step(1, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    rst = 1;
    step(-1, -1, 0, 5'd0, 32'h0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 5'd14, 32'h77, 32'h0, 0);
    step(0, 1, 1, 5'd14, 32'h77, 1, 0, 0);
`ifdef MEM_ALIGN_EXC_EN
    // Misaligned half and word loads
    drive(0, 0, 1, 1, 0, 1, 1, 5'd15, 32'h7001, 32'h1234_5678, 0);
    step(0, 0, 0, 5'd0, 32'h0, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 0, 0, 5'd16, 32'h7002, 32'h1234_5678, 1);
    step(0, 0, 0, 5'd0, 32'h0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    step(0, 0, 0, 5'd0, 32'h0, 0, 0, 0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
